// File: rtl/lc3b_fetch.sv
// LC-3b instruction fetch stage: word reads into a small {instr, pc+2} buffer drained by decode.
// Optional performance counters are compiled in when LC3B_FETCH_PERF_EN is defined.
module lc3b_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  output logic [15:0] ir_data,
  output logic [15:0] ir_pc,
  input  logic        ir_ready
`ifdef LC3B_FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetches,
  output logic [15:0] perf_flushes
`endif
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {REQ, WAIT_SPACE, DRAIN} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
  } entry_t;

  state_t      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] drain_pc_q, drain_pc_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  logic [2:0]  count_q, count_d, count_after_pop;
  logic        pop, push;
  entry_t      fifo_q [DEPTH];

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    pop             = ir_valid & ir_ready;
    count_after_pop = count_q - {2'b00, pop};
    push            = 1'b0;
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    drain_pc_d      = drain_pc_q;
    head_d          = pop ? ptr_inc(head_q) : head_q;
    tail_d          = tail_q;
    count_d         = count_after_pop;

    case (state_q)
      REQ: begin
        if (mem_resp) begin
          push       = 1'b1;
          tail_d     = ptr_inc(tail_q);
          count_d    = count_after_pop + 3'd1;
          fetch_pc_d = fetch_pc_q + 16'd2;
          state_d    = (count_d < DEPTH_C) ? REQ : WAIT_SPACE;
        end
      end
      WAIT_SPACE: if (count_after_pop < DEPTH_C) state_d = REQ;
      DRAIN:      if (mem_resp) state_d = REQ;
      default:    state_d = REQ;
    endcase

    // Redirect wins over the normal flow; this cycle's pop has already been counted as consumed.
    if (redirect) begin
      push       = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[15:1], 1'b0};
      if (state_q == REQ && !mem_resp) begin
        state_d    = DRAIN;
        drain_pc_d = fetch_pc_q;
      end else if (state_q == DRAIN && !mem_resp) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REQ;
      fetch_pc_q <= {RESET_PC[15:1], 1'b0};
      drain_pc_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drain_pc_q <= drain_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the buffer is reset because its head drives ir_data/ir_pc, which must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[tail_q] <= '{instr: mem_rdata, pc_plus2: fetch_pc_q + 16'd2};
    end
  end

  // During DRAIN the read must stay at the address it was issued with, not the new target.
  assign mem_read    = (state_q != WAIT_SPACE);
  assign mem_address = (state_q == DRAIN) ? drain_pc_q : fetch_pc_q;
  assign ir_valid    = (count_q != 3'd0);
  assign ir_data     = fifo_q[head_q].instr;
  assign ir_pc       = fifo_q[head_q].pc_plus2;

`ifdef LC3B_FETCH_PERF_EN
  logic flush_drops;
  assign flush_drops = redirect && ((count_after_pop != 3'd0) || (state_q != WAIT_SPACE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetches <= '0;
      perf_flushes <= '0;
    end else begin
      if (push && perf_fetches != 16'hFFFF)        perf_fetches <= perf_fetches + 16'd1;
      if (flush_drops && perf_flushes != 16'hFFFF) perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: doc/lc3b_fetch.md
# lc3b_fetch

Instruction fetch stage for the LC-3b datapath. It issues word reads to instruction memory at the fetch PC and buffers returned instruction words with their incremented PC in a small FIFO. It presents the head entry to the instruction register / decode stage with a valid/ready handshake. A redirect input from the control unit flushes the buffer and restarts fetch at a new address, for branches, JMP, JSR and TRAP.

## Interface
- `DEPTH`, 2: instruction buffer entries; must be 1 to 4.
- `RESET_PC`, 16'h0000: first fetch address after reset.

Ports:
- `clk`  in  1  — system clock, rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `mem_address`  out  16  — instruction read address, always word aligned (bit 0 = 0).
- `mem_read`  out  1  — read request.
- `mem_rdata`  in  16  — read data, valid in the `mem_resp` cycle.
- `mem_resp`  in  1  — one-cycle read completion.
- `redirect`  in  1  — flush the buffer and restart fetch.
- `redirect_pc`  in  16  — new fetch address; bit 0 is ignored.
- `ir_valid`  out  1  — buffer head is valid.
- `ir_data`  out  16  — head instruction word, routed to the IR `in` port.
- `ir_pc`  out  16  — head fetch address + 2; this is the architectural PC during execute.
- `ir_ready`  in  1  — consumer accepts the head this cycle.

## Operation
- Registered state:
  - FSM `REQ` / `WAIT_SPACE` / `DRAIN`
  - `fetch_pc[15:0]`
  - FIFO of DEPTH entries `{instr, pc_plus2}` with head/tail pointers
  - `count` of valid entries
- `REQ`:
  - Drive `mem_read` = 1 and `mem_address` = `fetch_pc`, both held stable until `mem_resp`.
  - On `mem_resp`: write `{mem_rdata, fetch_pc+2}` at the tail, then set `fetch_pc` to `fetch_pc+2` (16-bit wrap, so 16'hFFFE -> 16'h0000).
  - Next state is `REQ` if the FIFO has space after this cycle's push and pop; otherwise `WAIT_SPACE`.
- `WAIT_SPACE`: `mem_read` = 0. Go to `REQ` on the first cycle in which `count` < DEPTH after any pop.
- `DRAIN`: a read was outstanding when `redirect` arrived. Memory cannot cancel a read, so:
  - Hold `mem_read` = 1 at the old address until `mem_resp`.
  - Discard the returned data.
  - Then go to `REQ` at the redirected `fetch_pc`.
- Pop: when `ir_valid` && `ir_ready`, advance head and decrement `count`. Push and pop in the same cycle leave `count` unchanged.
- Redirect (any state):
  - Applies after that cycle's pop, so a handshake completing in the redirect cycle counts as consumed.
  - All remaining entries are flushed, so `count` = 0 next cycle.
  - `fetch_pc` <= {`redirect_pc[15:1]`, 1'b0}.
  - Next state:
    - `REQ` state with `mem_resp` = 1 this cycle: the response is discarded; next state `REQ`.
    - `REQ` state with `mem_resp` = 0: `DRAIN`.
    - `WAIT_SPACE`: `REQ`.
    - `DRAIN`: stays `DRAIN` with the updated target, unless `mem_resp` = 1 this cycle, in which case `REQ`.
- `ir_valid` = (`count` != 0). `ir_data` and `ir_pc` come from the head entry and are don't-care when `ir_valid` = 0.

## Timing
- Reset (asynchronous, immediate):
  - State `REQ`, `fetch_pc` = `RESET_PC`, `count` = 0, pointers = 0.
  - Outputs: `mem_read` = 1, `mem_address` = `RESET_PC`, `ir_valid` = 0, `ir_data` = 0, `ir_pc` = 0.
- Reset asserted mid-read abandons the read. The memory model must tolerate this.
- Latency: `mem_resp` in cycle N -> `ir_valid` = 1 in cycle N+1. There is no bypass.
- Back-to-back reads: a new request is presented in cycle N+1 when space remains, giving 1 instruction per memory response.
- Redirect in cycle N with no outstanding read -> `mem_read` at the new address in cycle N+1.
- `ir_valid`, `ir_data` and `ir_pc` are register outputs. The only combinational paths are from `ir_ready` and `redirect` into next-state logic.

## Configuration
- `LC3B_FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetches` (out, 16) and `perf_flushes` (out, 16), both reset to 0 and saturating at 16'hFFFF.
  - `perf_fetches` increments on each pushed (non-discarded) response.
  - `perf_flushes` increments on each `redirect` cycle that drops at least one buffered entry or an outstanding read.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset with `RESET_PC` = 16'h3000 and memory responding in 2 cycles, `ir_ready` = 1: entries 16'h3000, 16'h3002, 16'h3004 appear with `ir_pc` = 16'h3002, 16'h3004, 16'h3006, in order, with no gaps beyond the memory latency.
- `ir_ready` = 0, DEPTH = 2: exactly 2 reads complete, then `mem_read` = 0 (`WAIT_SPACE`). One pop -> exactly 1 new read issued.
- Redirect to 16'h4001 while a read at 16'h3004 is outstanding: `mem_read` stays at 16'h3004 until `mem_resp`, that data never appears, the next address is 16'h4000, and the first valid entry has `ir_pc` = 16'h4002.
- Redirect in the same cycle as a pop and a `mem_resp` with 2 entries buffered: the popped entry is consumed, the other entry and the response are dropped, and `count` = 0 in the next cycle.
- `fetch_pc` = 16'hFFFE: the entry has `ir_pc` = 16'h0000, and the next `mem_address` = 16'h0000.
- Reset asserted mid-`DRAIN`: `ir_valid` = 0 and `mem_address` = `RESET_PC` immediately. With `LC3B_FETCH_PERF_EN` defined, both counters read 0.
